// File: rtl/mips16_pkg.sv
// mips16_pkg: shared MIPS-16 register file widths, register-zero constant and types
package mips16_pkg;
  localparam int DW = 16;
  localparam int NREG = 16;
  localparam int AW = $clog2(NREG);
  typedef logic [AW-1:0] reg_addr_t;
  typedef logic [DW-1:0] word_t;
  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending bits, RAW stall and pending count; WB_BYPASS_EN lets a landing writeback release stall
module wb_scoreboard import mips16_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic          iss_we,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic          stall,
  output logic [AW:0]   pend_cnt
);
  logic [NREG-1:0] pending, eff, set_mask, clr_mask;
  logic set_v, clr_v;
  assign clr_mask = (wb_we && wb_rd != REG_ZERO) ? NREG'(1) << wb_rd : '0;
`ifdef WB_BYPASS_EN
  assign eff = pending & ~clr_mask;
`else
  assign eff = pending;
`endif
  assign stall = eff[rs_addr] | eff[rt_addr] | (iss_we & eff[iss_rd]);
  assign set_v = iss_we && iss_rd != REG_ZERO && !stall;
  assign set_mask = set_v ? NREG'(1) << iss_rd : '0;
  assign clr_v = |(pending & clr_mask);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pending <= '0;
      pend_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      pend_cnt <= pend_cnt + (AW+1)'(set_v) - (AW+1)'(clr_v);
    end
  a_no_double_set: assert property (@(posedge clk) disable iff (!reset)
    !(set_v && pending[iss_rd] && !clr_mask[iss_rd]));
endmodule

// File: rtl/wb_regfile_port.sv
// wb_regfile_port: MIPS-16 register file taking ans_wb writebacks with RAW scoreboard; WB_BYPASS_EN adds write-through read bypass
module wb_regfile_port import mips16_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] ans_wb,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_rd,
  input  logic          iss_we,
  input  logic [AW-1:0] iss_rd,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          stall,
  output logic [AW:0]   pend_cnt
);
  logic [DW-1:0] rf [NREG];
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NREG; i++) rf[i] <= '0;
    else if (wb_we && wb_rd != REG_ZERO) rf[wb_rd] <= ans_wb;
`ifdef WB_BYPASS_EN
  logic byp;
  assign byp = wb_we && wb_rd != REG_ZERO;
  assign rs_data = (byp && wb_rd == rs_addr) ? ans_wb : rf[rs_addr];
  assign rt_data = (byp && wb_rd == rt_addr) ? ans_wb : rf[rt_addr];
`else
  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];
`endif
  wb_scoreboard u_sb (
    .clk(clk), .reset(reset), .wb_we(wb_we), .wb_rd(wb_rd),
    .iss_we(iss_we), .iss_rd(iss_rd), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .stall(stall), .pend_cnt(pend_cnt)
  );
endmodule
